// File: rtl/fifo_stream.sv
// Single-clock valid/ready stream FIFO with optional registered output,
// occupancy count, almost-full/empty flags, synchronous flush and drop pulse.
//
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (sync clear)
//   data_i/valid_i/ready_o : write side
//   data_o/valid_o/ready_i : read side
//   count_o  : entries held in memory (excludes the output register)
//   afull_o  : count_o >= AFULL_P
//   aempty_o : count_o <= AEMPTY_P
//   drop_o   : one-cycle pulse, a write was refused in the previous cycle
module fifo_stream #(
  parameter int WIDTH_P  = 8,
  parameter int DEPTH_P  = 16,
  parameter int FWFT_P   = 1,
  parameter int AFULL_P  = DEPTH_P - 2,
  parameter int AEMPTY_P = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [WIDTH_P-1:0]         data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [WIDTH_P-1:0]         data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH_P):0]   count_o,
  output logic                       afull_o,
  output logic                       aempty_o,
  output logic                       drop_o
);

  localparam int AW = $clog2(DEPTH_P);
  localparam int PW = AW + 1;

  logic [WIDTH_P-1:0] mem_q [DEPTH_P];
  logic [PW-1:0]      wr_q, wr_d;
  logic [PW-1:0]      rd_q, rd_d;
  logic               drop_q, drop_d;
  logic               push;
  logic               rd_adv;
  logic [WIDTH_P-1:0] head;

  // Extra pointer MSB tells full from empty; count is the modular distance.
  assign count_o  = wr_q - rd_q;
  assign ready_o  = ~rst_i & (count_o != PW'(DEPTH_P));
  assign push     = valid_i & ready_o;
  assign head     = mem_q[rd_q[AW-1:0]];
  assign afull_o  = ~rst_i & (count_o >= PW'(AFULL_P));
  assign aempty_o = rst_i | (count_o <= PW'(AEMPTY_P));
  assign drop_d   = valid_i & ~ready_o & ~rst_i & ~flush_i;
  assign drop_o   = drop_q;

  always_comb begin
    wr_d = wr_q + {{(PW-1){1'b0}}, push};
    rd_d = rd_q + {{(PW-1){1'b0}}, rd_adv};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      drop_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  if (FWFT_P != 0) begin : g_fwft
    assign valid_o = ~rst_i & (count_o != '0);
    assign data_o  = head;
    assign rd_adv  = valid_o & ready_i;
  end else begin : g_reg
    logic [WIDTH_P-1:0] dout_q;
    logic               dval_q;

    // Refill the output stage whenever it is empty or being consumed.
    assign rd_adv  = ~rst_i & (count_o != '0) & (~dval_q | ready_i);
    assign valid_o = ~rst_i & dval_q;
    assign data_o  = dout_q;

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        dval_q <= 1'b0;
        dout_q <= '0;
      end else if (rd_adv) begin
        dval_q <= 1'b1;
        dout_q <= head;
      end else if (ready_i) begin
        dval_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream.sv
// Bench for fifo_stream: FWFT and registered-output instances driven in
// lockstep and compared every cycle against queue-based reference models.
module tb_fifo_stream;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       flush_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b0;
  logic [7:0] data_i = '0;

  logic [1:0] rdy_o, val_o, af_o, ae_o, drp_o;
  logic [7:0] dat_o [2];
  logic [2:0] cnt_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: [0] fall-through, [1] registered output
  logic [7:0] mq [2][$];
  bit         ho [2];
  logic [7:0] ov [2];
  bit         md [2];
  logic [7:0] got0 [$];
  logic [7:0] got1 [$];

  always #5 clk = ~clk;

  fifo_stream #(
    .WIDTH_P(8), .DEPTH_P(4), .FWFT_P(1), .AFULL_P(3), .AEMPTY_P(1)
  ) u_fwft (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(rdy_o[0]),
    .data_o(dat_o[0]), .valid_o(val_o[0]), .ready_i(ready_i),
    .count_o(cnt_o[0]), .afull_o(af_o[0]), .aempty_o(ae_o[0]),
    .drop_o(drp_o[0])
  );

  fifo_stream #(
    .WIDTH_P(8), .DEPTH_P(4), .FWFT_P(0), .AFULL_P(3), .AEMPTY_P(1)
  ) u_reg (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(rdy_o[1]),
    .data_o(dat_o[1]), .valid_o(val_o[1]), .ready_i(ready_i),
    .count_o(cnt_o[1]), .afull_o(af_o[1]), .aempty_o(ae_o[1]),
    .drop_o(drp_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < 2; i++) begin
      int n  = mq[i].size();
      bit ev = !rst_i && ((i == 0) ? (n > 0) : ho[i]);
      chk($sformatf("ready%0d", i), rdy_o[i], !rst_i && n != 4);
      chk($sformatf("valid%0d", i), val_o[i], ev);
      chk($sformatf("count%0d", i), cnt_o[i], n);
      chk($sformatf("afull%0d", i), af_o[i], !rst_i && n >= 3);
      chk($sformatf("aempty%0d", i), ae_o[i], rst_i || n <= 1);
      chk($sformatf("drop%0d", i), drp_o[i], md[i]);
      if (ev) begin
        chk($sformatf("data%0d", i), dat_o[i],
            (i == 0) ? mq[i][0] : ov[i]);
      end
    end
  endtask

  task automatic step_model(input bit r, input bit f, input bit v,
                            input bit rdy, input logic [7:0] d);
    for (int i = 0; i < 2; i++) begin
      if (r || f) begin
        mq[i].delete();
        ho[i] = 1'b0;
        md[i] = 1'b0;
      end else begin
        int n   = mq[i].size();
        bit acc = (n != 4);
        if (i == 0) begin
          if (n > 0 && rdy) void'(mq[i].pop_front());
        end else begin
          if (n > 0 && (!ho[i] || rdy)) begin
            ov[i] = mq[i].pop_front();
            ho[i] = 1'b1;
          end else if (rdy) begin
            ho[i] = 1'b0;
          end
        end
        if (v && acc) mq[i].push_back(d);
        md[i] = v && !acc;
      end
    end
  endtask

  task automatic tick(input bit r, input bit f, input bit v,
                      input bit rdy, input logic [7:0] d);
    rst_i   = r;
    flush_i = f;
    valid_i = v;
    ready_i = rdy;
    data_i  = d;
    #2;
    check_outs();
    if (val_o[0] && ready_i) got0.push_back(dat_o[0]);
    if (val_o[1] && ready_i) got1.push_back(dat_o[1]);
    @(posedge clk);
    step_model(r, f, v, rdy, d);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp0 [4];
    logic [7:0] exp1 [5];
    exp0 = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 2; i++) begin
      ho[i] = 1'b0;
      md[i] = 1'b0;
      ov[i] = '0;
    end

    // reset held for two edges
    @(posedge clk);
    @(negedge clk);
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 8'h00);

    // fill then overflow
    tick(0, 0, 1, 0, 8'h11);
    tick(0, 0, 1, 0, 8'h22);
    tick(0, 0, 1, 0, 8'h33);
    tick(0, 0, 1, 0, 8'h44);
    tick(0, 0, 1, 0, 8'h55);
    chk("drop_pulse", drp_o[0], 1'b1);
    tick(0, 0, 0, 0, 8'h00);

    // drain
    got0.delete();
    got1.delete();
    for (int k = 0; k < 8; k++) tick(0, 0, 0, 1, 8'h00);
    chk("drain_len0", got0.size(), 4);
    chk("drain_len1", got1.size(), 5);
    for (int k = 0; k < 4; k++) begin
      if (k < got0.size()) chk("drain_data0", got0[k], exp0[k]);
    end
    for (int k = 0; k < 5; k++) begin
      if (k < got1.size()) chk("drain_data1", got1[k], exp1[k]);
    end

    // streaming at full rate
    for (int k = 0; k < 32; k++) tick(0, 0, 1, 1, 8'(k + 8'h80));
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 1, 8'h00);

    // wrap rounds
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int k = 0; k < 3; k++) tick(0, 0, 1, 0, 8'(rnd * 16 + k));
      for (int k = 0; k < 3; k++) tick(0, 0, 0, 1, 8'h00);
    end
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 1, 8'h00);

    // flush with concurrent push and pop
    for (int k = 0; k < 3; k++) tick(0, 0, 1, 0, 8'(8'h31 + k));
    tick(0, 1, 1, 1, 8'hEE);
    got0.delete();
    got1.delete();
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 1, 8'h00);
    chk("flush_out0", got0.size(), 0);
    chk("flush_out1", got1.size(), 0);

    // random traffic with occasional flush and reset
    for (int k = 0; k < 600; k++) begin
      bit r = ($urandom_range(63) == 0);
      bit f = ($urandom_range(31) == 0);
      bit v = ($urandom_range(3) != 0);
      bit q = ($urandom_range(2) != 0);
      tick(r, f, v, q, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
